// File: rtl/vec_cfg_sequencer_pkg.sv
// Shared types and field layout for the vector configuration sequencer.
// Pure declarations: no logic, no latency.
// Holds the request-kind enum, vtype field offsets, and the FSM state encoding.
package vec_cfg_sequencer_pkg;

    // Request kind as classified by vector decode; RSVD behaves like VSETVL.
    typedef enum logic [1:0] {
        KIND_VSETVLI  = 2'b00,
        KIND_VSETIVLI = 2'b01,
        KIND_VSETVL   = 2'b10,
        KIND_RSVD     = 2'b11
    } cfg_kind_e;

    // vtype field offsets.
    localparam int VLMUL_LSB = 0;
    localparam int VSEW_LSB  = 3;
    localparam int VTA_BIT   = 6;
    localparam int VMA_BIT   = 7;

    // vlmul encoding that has no defined LMUL.
    localparam logic [2:0] VLMUL_RSVD = 3'b100;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Low byte of vtype; everything above it is reserved (or the vill bit).
    typedef struct packed {
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

endpackage

// File: rtl/vec_cfg_sequencer_if.sv
// Request/response bundle between vector decode, the sequencer and scalar writeback.
// Pure wiring: no latency.
// valid/ready on both the request side and the writeback side.
interface vec_cfg_sequencer_if #(
    parameter int XLEN = 32
);
    logic            cfg_valid_i;
    logic            cfg_ready_o;
    logic [1:0]      cfg_kind_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rd_addr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [10:0]     zimm_i;
    logic [4:0]      uimm_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [4:0]      resp_rd_addr_o;
    logic [XLEN-1:0] resp_rd_data_o;
    logic            resp_wr_en_o;

    // Decode / writeback side.
    modport master (
        output cfg_valid_i, cfg_kind_i, rs1_addr_i, rd_addr_i, rs1_data_i,
               rs2_data_i, zimm_i, uimm_i, resp_ready_i,
        input  cfg_ready_o, resp_valid_o, resp_rd_addr_o, resp_rd_data_o, resp_wr_en_o
    );

    // Sequencer side.
    modport slave (
        input  cfg_valid_i, cfg_kind_i, rs1_addr_i, rd_addr_i, rs1_data_i,
               rs2_data_i, zimm_i, uimm_i, resp_ready_i,
        output cfg_ready_o, resp_valid_o, resp_rd_addr_o, resp_rd_data_o, resp_wr_en_o
    );
endinterface

// File: rtl/vec_vlmax_calc.sv
// VLMAX and vill from vsew/vlmul using shifts only.
// Combinational, zero latency.
// No handshake; result is meaningful only while vill is low.
module vec_vlmax_calc
    import vec_cfg_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    output logic [XLEN-1:0] vlmax,
    output logic            vill
);

    logic [31:0] sew_bits;
    logic [31:0] base;
    logic [31:0] scaled;
    logic [2:0]  frac_sh;
    logic        sew_bad;
    logic        frac_bad;

    // Legality checks and VLEN/SEW*LMUL computed as a pair of shifts.
    always_comb begin
        sew_bits = 32'd8 << vsew;
        sew_bad  = sew_bits > 32'(ELEN);
        // For 101/110/111 this is 3/2/1, i.e. the LMUL denominator exponent.
        frac_sh  = 3'd0 - vlmul;
        // SEW > ELEN*LMUL with LMUL = 1/2^frac_sh, rearranged to avoid fractions.
        frac_bad = vlmul[2] && (vlmul != VLMUL_RSVD)
                   && ((sew_bits << frac_sh) > 32'(ELEN));
        base     = 32'(VLEN) >> ({2'b00, vsew} + 5'd3);
        if (!vlmul[2]) begin
            scaled = base << vlmul[1:0];
        end else begin
            scaled = base >> frac_sh;
        end
        vill  = sew_bad || (vlmul == VLMUL_RSVD) || frac_bad;
        vlmax = XLEN'(scaled);
    end

endmodule

// File: rtl/vec_cfg_sequencer.sv
// Sequences VSETVLI/VSETIVLI/VSETVL: computes vl, owns the vl/vtype CSRs, returns vl as rd writeback.
// Accept at cycle N, CSRs and resp_valid_o visible at N+2; one request per 3 cycles at best.
// Accepts only in IDLE; response is held stable until resp_ready_i. Perf counters under VEC_CFG_PERF_EN.
module vec_cfg_sequencer
    import vec_cfg_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    vec_cfg_sequencer_if.slave bus,
    output logic [XLEN-1:0] vl_o,
    output logic [XLEN-1:0] vtype_o,
    output logic            busy_o
`ifdef VEC_CFG_PERF_EN
    ,
    output logic [31:0]     cfg_count_o,
    output logic [31:0]     vill_count_o
`endif
);

    localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    cfg_kind_e       kind_q;
    logic [4:0]      rs1_addr_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] avl_q;
    logic [XLEN-1:0] vtype_cand_q;
    logic [XLEN-1:0] vl_q;
    logic [XLEN-1:0] vtype_q;
    logic [XLEN-1:0] resp_data_q;
    logic [4:0]      resp_rd_addr_q;
    logic            resp_wr_en_q;
    logic            vill_q;

    logic [XLEN-1:0] vlmax;
    logic            calc_vill;
    logic            rsvd_bad;
    logic            new_vill;
    logic [XLEN-1:0] avl;
    logic [XLEN-1:0] new_vl;
    logic [XLEN-1:0] new_vtype;

    vec_vlmax_calc #(
        .XLEN (XLEN),
        .VLEN (VLEN),
        .ELEN (ELEN)
    ) u_vlmax (
        .vsew  (vtype_cand_q[VSEW_LSB +: 3]),
        .vlmul (vtype_cand_q[VLMUL_LSB +: 3]),
        .vlmax (vlmax),
        .vill  (calc_vill)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d          = state_q;
        bus.cfg_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        busy_o           = 1'b1;
        case (state_q)
            IDLE: begin
                bus.cfg_ready_o = 1'b1;
                busy_o          = 1'b0;
                if (bus.cfg_valid_i) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result of the CALC cycle: legality, AVL selection and min(AVL, VLMAX).
    always_comb begin
        // Bits above the vtype byte, including the source's own vill bit, make the vtype illegal.
        rsvd_bad = |vtype_cand_q[XLEN-1:8];
        new_vill = calc_vill || rsvd_bad;
        if (kind_q == KIND_VSETIVLI) begin
            avl = avl_q;
        end else if (rs1_addr_q != 5'd0) begin
            avl = avl_q;
        end else if (rd_addr_q != 5'd0) begin
            avl = '1;
        end else begin
            // rs1=rd=x0 keeps the current vl, clipped to the new VLMAX.
            avl = vl_q;
        end
        new_vl    = (avl < vlmax) ? avl : vlmax;
        new_vtype = {{(XLEN-8){1'b0}}, vtype_cand_q[7:0]};
        if (new_vill) begin
            new_vl    = '0;
            new_vtype = VILL_VTYPE;
        end
    end

    // Request capture in IDLE; CSR and response registers written only at the end of CALC.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q         <= KIND_VSETVLI;
            rs1_addr_q     <= '0;
            rd_addr_q      <= '0;
            avl_q          <= '0;
            vtype_cand_q   <= '0;
            vl_q           <= '0;
            vtype_q        <= VILL_VTYPE;
            resp_data_q    <= '0;
            resp_rd_addr_q <= '0;
            resp_wr_en_q   <= 1'b0;
            vill_q         <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.cfg_valid_i) begin
                kind_q     <= cfg_kind_e'(bus.cfg_kind_i);
                rs1_addr_q <= bus.rs1_addr_i;
                rd_addr_q  <= bus.rd_addr_i;
                case (cfg_kind_e'(bus.cfg_kind_i))
                    KIND_VSETVLI: begin
                        avl_q        <= bus.rs1_data_i;
                        vtype_cand_q <= XLEN'(bus.zimm_i);
                    end
                    KIND_VSETIVLI: begin
                        avl_q        <= XLEN'(bus.uimm_i);
                        vtype_cand_q <= XLEN'(bus.zimm_i[9:0]);
                    end
                    default: begin
                        avl_q        <= bus.rs1_data_i;
                        vtype_cand_q <= bus.rs2_data_i;
                    end
                endcase
            end
            if (state_q == CALC) begin
                vl_q           <= new_vl;
                vtype_q        <= new_vtype;
                resp_data_q    <= new_vl;
                resp_rd_addr_q <= rd_addr_q;
                resp_wr_en_q   <= (rd_addr_q != 5'd0);
                vill_q         <= new_vill;
            end
        end
    end

    assign vl_o               = vl_q;
    assign vtype_o            = vtype_q;
    assign bus.resp_rd_data_o = resp_data_q;
    assign bus.resp_rd_addr_o = resp_rd_addr_q;
    assign bus.resp_wr_en_o   = resp_wr_en_q;

`ifdef VEC_CFG_PERF_EN
    logic [31:0] cfg_cnt_q;
    logic [31:0] vill_cnt_q;

    // Count completed writebacks and the illegal-vtype subset; both wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_cnt_q  <= '0;
            vill_cnt_q <= '0;
        end else if (state_q == RESP && bus.resp_ready_i) begin
            cfg_cnt_q <= cfg_cnt_q + 32'd1;
            if (vill_q) begin
                vill_cnt_q <= vill_cnt_q + 32'd1;
            end
        end
    end

    assign cfg_count_o  = cfg_cnt_q;
    assign vill_count_o = vill_cnt_q;
`endif

endmodule

// File: tb/tb_vec_cfg_sequencer.sv
// Directed-vector bench for vec_cfg_sequencer (VLEN=512, ELEN=32, XLEN=32).
// Table of requests with hand-computed vl/vtype, plus reset-in-CALC sequence.
// Checks exact N+2 latency, response stability under backpressure and reset values.
module tb_vec_cfg_sequencer;

    localparam logic [31:0] VILL = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] vl;
    logic [31:0] vtype;
    logic        busy;
`ifdef VEC_CFG_PERF_EN
    logic [31:0] cfg_count;
    logic [31:0] vill_count;
`endif

    always #5 clk = ~clk;

    vec_cfg_sequencer_if #(.XLEN(32)) bus ();

    vec_cfg_sequencer #(
        .XLEN (32),
        .VLEN (512),
        .ELEN (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .vl_o    (vl),
        .vtype_o (vtype),
        .busy_o  (busy)
`ifdef VEC_CFG_PERF_EN
        ,
        .cfg_count_o  (cfg_count),
        .vill_count_o (vill_count)
`endif
    );

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [10:0] zimm;
        logic [4:0]  uimm;
        int          hold;
        logic [31:0] exp_vl;
        logic [31:0] exp_vtype;
        logic        exp_wr_en;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cfg_cnt  = 0;
    int exp_vill_cnt = 0;

    function automatic vec_t mk(input logic [1:0] kind, input logic [4:0] rs1, input logic [4:0] rd,
                                input logic [31:0] rs1_data, input logic [31:0] rs2_data,
                                input logic [10:0] zimm, input logic [4:0] uimm, input int hold,
                                input logic [31:0] exp_vl, input logic [31:0] exp_vtype,
                                input logic exp_wr_en);
        vec_t v;
        v.kind = kind; v.rs1 = rs1; v.rd = rd; v.rs1_data = rs1_data; v.rs2_data = rs2_data;
        v.zimm = zimm; v.uimm = uimm; v.hold = hold; v.exp_vl = exp_vl;
        v.exp_vtype = exp_vtype; v.exp_wr_en = exp_wr_en;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 32'(bus.cfg_ready_o), 32'd1);
        bus.cfg_valid_i  = 1'b1;
        bus.cfg_kind_i   = v.kind;
        bus.rs1_addr_i   = v.rs1;
        bus.rd_addr_i    = v.rd;
        bus.rs1_data_i   = v.rs1_data;
        bus.rs2_data_i   = v.rs2_data;
        bus.zimm_i       = v.zimm;
        bus.uimm_i       = v.uimm;
        bus.resp_ready_i = (v.hold == 0);
        // Accept edge (cycle N ends); now in CALC.
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        check({tag, "_calc_ready"}, 32'(bus.cfg_ready_o), 32'd0);
        check({tag, "_calc_valid"}, 32'(bus.resp_valid_o), 32'd0);
        check({tag, "_calc_busy"}, 32'(busy), 32'd1);
        // Cycle N+2: response and CSRs visible.
        @(posedge clk); #1;
        check({tag, "_resp_valid"}, 32'(bus.resp_valid_o), 32'd1);
        check({tag, "_rd_data"}, bus.resp_rd_data_o, v.exp_vl);
        check({tag, "_wr_en"}, 32'(bus.resp_wr_en_o), 32'(v.exp_wr_en));
        check({tag, "_rd_addr"}, 32'(bus.resp_rd_addr_o), 32'(v.rd));
        check({tag, "_vl"}, vl, v.exp_vl);
        check({tag, "_vtype"}, vtype, v.exp_vtype);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.resp_valid_o), 32'd1);
            check({tag, "_hold_data"}, bus.resp_rd_data_o, v.exp_vl);
            check({tag, "_hold_wr_en"}, 32'(bus.resp_wr_en_o), 32'(v.exp_wr_en));
            check({tag, "_hold_ready"}, 32'(bus.cfg_ready_o), 32'd0);
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_valid"}, 32'(bus.resp_valid_o), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        exp_cfg_cnt++;
        if (v.exp_vtype == VILL) exp_vill_cnt++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vl"}, vl, 32'd0);
        check({tag, "_vtype"}, vtype, VILL);
        check({tag, "_ready"}, 32'(bus.cfg_ready_o), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
        check({tag, "_wr_en"}, 32'(bus.resp_wr_en_o), 32'd0);
        check({tag, "_rd_addr"}, 32'(bus.resp_rd_addr_o), 32'd0);
        check({tag, "_rd_data"}, bus.resp_rd_data_o, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef VEC_CFG_PERF_EN
        check({tag, "_cfg_count"}, cfg_count, 32'd0);
        check({tag, "_vill_count"}, vill_count, 32'd0);
`endif
    endtask

    initial begin
        //               kind   rs1    rd     rs1_data      rs2_data     zimm     uimm  hold vl       vtype      wr
        vecs[0]  = mk(2'b00, 5'd5, 5'd6, 32'd100,      32'h0,       11'h010, 5'd0,  0, 32'd16,  32'h10,  1'b1);
        vecs[1]  = mk(2'b01, 5'd0, 5'd7, 32'd0,        32'h0,       11'h003, 5'd5,  0, 32'd5,   32'h03,  1'b1);
        vecs[2]  = mk(2'b00, 5'd0, 5'd1, 32'd0,        32'h0,       11'h00F, 5'd0,  0, 32'd16,  32'h0F,  1'b1);
        vecs[3]  = mk(2'b10, 5'd2, 5'd3, 32'd50,       32'h4,       11'h000, 5'd0,  0, 32'd0,   VILL,    1'b1);
        vecs[4]  = mk(2'b10, 5'd2, 5'd3, 32'd50,       32'h18,      11'h000, 5'd0,  0, 32'd0,   VILL,    1'b1);
        vecs[5]  = mk(2'b00, 5'd3, 5'd4, 32'd10,       32'h0,       11'h010, 5'd0,  0, 32'd10,  32'h10,  1'b1);
        vecs[6]  = mk(2'b00, 5'd0, 5'd0, 32'd0,        32'h0,       11'h010, 5'd0,  4, 32'd10,  32'h10,  1'b0);
        vecs[7]  = mk(2'b00, 5'd1, 5'd2, 32'd1000,     32'h0,       11'h0D1, 5'd0,  0, 32'd32,  32'hD1,  1'b1);
        vecs[8]  = mk(2'b11, 5'd1, 5'd2, 32'd7,        32'h0,       11'h000, 5'd0,  0, 32'd7,   32'h00,  1'b1);
        vecs[9]  = mk(2'b10, 5'd1, 5'd2, 32'd7,        32'h100,     11'h000, 5'd0,  0, 32'd0,   VILL,    1'b1);
        vecs[10] = mk(2'b00, 5'd1, 5'd2, 32'd3,        32'h0,       11'h005, 5'd0,  0, 32'd0,   VILL,    1'b1);
        vecs[11] = mk(2'b00, 5'd1, 5'd2, 32'd3,        32'h0,       11'h017, 5'd0,  0, 32'd0,   VILL,    1'b1);
        vecs[12] = mk(2'b01, 5'd0, 5'd8, 32'd0,        32'h0,       11'h408, 5'd31, 1, 32'd31,  32'h08,  1'b1);
        vecs[13] = mk(2'b00, 5'd1, 5'd2, 32'd3,        32'h0,       11'h408, 5'd0,  0, 32'd0,   VILL,    1'b1);
        vecs[14] = mk(2'b00, 5'd9, 5'd0, 32'hFFFFFFFF, 32'h0,       11'h003, 5'd0,  0, 32'd512, 32'h03,  1'b0);
        vecs[15] = mk(2'b00, 5'd0, 5'd0, 32'd0,        32'h0,       11'h010, 5'd0,  0, 32'd16,  32'h10,  1'b0);
        vecs[16] = mk(2'b00, 5'd4, 5'd5, 32'd0,        32'h0,       11'h010, 5'd0,  0, 32'd0,   32'h10,  1'b1);
        vecs[17] = mk(2'b00, 5'd1, 5'd2, 32'd100,      32'h0,       11'h006, 5'd0,  0, 32'd16,  32'h06,  1'b1);

        bus.cfg_valid_i  = 1'b0;
        bus.cfg_kind_i   = 2'b00;
        bus.rs1_addr_i   = '0;
        bus.rd_addr_i    = '0;
        bus.rs1_data_i   = '0;
        bus.rs2_data_i   = '0;
        bus.zimm_i       = '0;
        bus.uimm_i       = '0;
        bus.resp_ready_i = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

`ifdef VEC_CFG_PERF_EN
        check("perf_cfg_count", cfg_count, 32'(exp_cfg_cnt));
        check("perf_vill_count", vill_count, 32'(exp_vill_cnt));
`endif

        // Reset asserted while a request is in CALC: no CSR write may follow.
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_kind_i  = 2'b00;
        bus.rs1_addr_i  = 5'd5;
        bus.rd_addr_i   = 5'd6;
        bus.rs1_data_i  = 32'd7;
        bus.zimm_i      = 11'h010;
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        check("rst_calc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("rst_calc");
        @(posedge clk); #1;
        check_reset_values("rst_calc_after");
        exp_cfg_cnt  = 0;
        exp_vill_cnt = 0;

        // rs1=rd=x0 right after reset keeps vl at its reset value of 0.
        run_vec(mk(2'b00, 5'd0, 5'd0, 32'd0, 32'h0, 11'h010, 5'd0, 0, 32'd0, 32'h10, 1'b0), 99);

`ifdef VEC_CFG_PERF_EN
        check("perf_cfg_count_end", cfg_count, 32'(exp_cfg_cnt));
        check("perf_vill_count_end", vill_count, 32'(exp_vill_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
